// File: rtl/dmem_responder_if.sv
// Request/response bus between a core (master) and the data-memory responder (slave).
// One request outstanding at a time; both channels use valid/ready handshakes.
interface dmem_responder_if #(
  parameter int AW = 14
);
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with byte write enables and a fixed response latency.
// Reads and writes both complete at the acceptance edge; the FSM only delays the response.
module dmem_responder #(
  parameter int AW      = 14,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(LATENCY + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          accept;

  // Handshake outputs decode the state register only, so no input reaches them combinationally.
  assign bus.req_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = (state_reg == ST_RESP);
  assign accept        = (state_reg == ST_IDLE) && bus.req_valid;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CW'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == CW'(1)) begin
          state_next = ST_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // One byte-wide array per lane; the response byte is the new byte if enabled, else the old one.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (accept && !rst && bus.req_we[gi]) begin
          mem[bus.req_addr] <= bus.req_wdata[8*gi +: 8];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_byte_reg <= '0;
        end else if (accept) begin
          rd_byte_reg <= bus.req_we[gi] ? bus.req_wdata[8*gi +: 8] : mem[bus.req_addr];
        end
      end

      assign bus.rsp_rdata[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate
endmodule
